// File: rtl/pdp8_iot_seq.sv
// pdp8_iot_seq: CPU-side IOT bus sequencer driving SETUP/IOP1/IOP2/IOP4 phases and the ION/IOF flip-flop.
module pdp8_iot_seq #(
  parameter int         PHASE_CYCLES = 2,
  parameter logic [3:0] ST_IDLE      = 4'h0,
  parameter logic [3:0] ST_SETUP     = 4'h1,
  parameter logic [3:0] ST_IOP1      = 4'h2,
  parameter logic [3:0] ST_IOP2      = 4'h3,
  parameter logic [3:0] ST_IOP4      = 4'h4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] ir,
  input  logic [11:0] ac_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] ac_out,
  output logic        skip,
  output logic        iot,
  output logic [3:0]  state,
  output logic [11:0] mb,
  output logic [5:0]  io_select,
  output logic [11:0] io_data_in,
  input  logic [11:0] io_data_out,
  input  logic        io_data_avail,
  input  logic        io_skip,
  input  logic        io_clear_ac,
  input  logic        io_interrupt,
  output logic        int_enable,
  output logic        int_request
);
  localparam int CW = PHASE_CYCLES > 1 ? $clog2(PHASE_CYCLES) : 1;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_P1, S_P2, S_P4, S_FIN} st_t;
  st_t st_q, st_d, after_setup, after_p1, after_p2;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] mb_q, mb_d, wac_q, wac_d, acout_q, acout_d;
  logic acc_q, acc_d, skip_q, skip_d, ien_q, ien_d, in_phase, last, is_iot, internal;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    mb_d = mb_q;
    wac_d = wac_q;
    acout_d = acout_q;
    acc_d = acc_q;
    skip_d = skip_q;
    ien_d = ien_q;
    is_iot = ir[11:9] == 3'b110;
    internal = is_iot && ir[8:3] == 6'd0;
    in_phase = st_q == S_P1 || st_q == S_P2 || st_q == S_P4;
    last = in_phase && cnt_q == CW'(PHASE_CYCLES - 1);
    after_p2 = mb_q[2] ? S_P4 : S_FIN;
    after_p1 = mb_q[1] ? S_P2 : after_p2;
    after_setup = mb_q[0] ? S_P1 : after_p1;
    case (st_q)
      S_IDLE: if (start) begin
        mb_d = ir;
        wac_d = ac_in;
        acc_d = 1'b0;
        st_d = (!is_iot || internal) ? S_FIN : S_SETUP;
        ien_d = !internal ? ien_q : ir[1] ? 1'b0 : ir[0] ? 1'b1 : ien_q;
      end
      S_SETUP: begin
        st_d = after_setup;
        cnt_d = '0;
      end
      S_P1, S_P2, S_P4: begin
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          wac_d = (io_clear_ac ? 12'd0 : wac_q) | (io_data_avail ? io_data_out : 12'd0);
          acc_d = acc_q | io_skip;
          st_d = st_q == S_P1 ? after_p1 : st_q == S_P2 ? after_p2 : S_FIN;
        end
      end
      S_FIN: begin
        acout_d = wac_q;
        skip_d = acc_q;
        st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      mb_q <= '0;
      wac_q <= '0;
      acout_q <= '0;
      acc_q <= 1'b0;
      skip_q <= 1'b0;
      ien_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      mb_q <= mb_d;
      wac_q <= wac_d;
      acout_q <= acout_d;
      acc_q <= acc_d;
      skip_q <= skip_d;
      ien_q <= ien_d;
    end
  end
  // Results are presented during FIN itself, then held from the registered copy.
  assign busy = st_q != S_IDLE;
  assign done = st_q == S_FIN;
  assign ac_out = done ? wac_q : acout_q;
  assign skip = done ? acc_q : skip_q;
  assign iot = st_q == S_SETUP || in_phase;
  assign state = st_q == S_SETUP ? ST_SETUP : st_q == S_P1 ? ST_IOP1 :
                 st_q == S_P2 ? ST_IOP2 : st_q == S_P4 ? ST_IOP4 : ST_IDLE;
  assign mb = mb_q;
  assign io_select = mb_q[8:3];
  assign io_data_in = wac_q;
  assign int_enable = ien_q;
  assign int_request = ien_q & io_interrupt;
endmodule

// File: doc/pdp8_iot_seq.md
Name: pdp8_iot_seq

Overview:
- CPU-side initiator of the programmed-I/O (IOT) bus. It is the counterpart of the device-side I/O responder and its device modules (TT, RF, KW).
- Accepts one decoded IOT instruction from the CPU core and drives iot, state, mb and io_select through SETUP and IOP1/IOP2/IOP4 phases.
- Samples the device returns (data, skip, clear-AC) and hands an updated AC and skip flag back to the core.
- Executes device-00 IOTs (ION/IOF) internally and gates the interrupt request.

Parameters:
- PHASE_CYCLES, 2, clocks per IOP phase (>=1); device returns sampled in the last cycle of each phase.
- ST_IDLE, 4'h0, state-bus code when no IOT is active.
- ST_SETUP, 4'h1, state-bus code during the setup cycle.
- ST_IOP1, 4'h2, state-bus code for the IOP1 phase.
- ST_IOP2, 4'h3, state-bus code for the IOP2 phase.
- ST_IOP4, 4'h4, state-bus code for the IOP4 phase.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to execute ir; honoured only when busy=0
- ir  in  12  instruction word
- ac_in  in  12  AC value at start
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- ac_out  out  12  resulting AC, valid while done=1 and held until the next done
- skip  out  1  skip result, valid while done=1 and held until the next done
- iot  out  1  IOT bus active
- state  out  4  phase code
- mb  out  12  latched instruction
- io_select  out  6  device code = ir[8:3]
- io_data_in  out  12  working AC presented to devices
- io_data_out  in  12  device read data
- io_data_avail  in  1  OR io_data_out into AC this phase
- io_skip  in  1  device skip
- io_clear_ac  in  1  clear AC this phase
- io_interrupt  in  1  OR of device interrupt flags
- int_enable  out  1  interrupt enable flip-flop
- int_request  out  1  = int_enable & io_interrupt (combinational)

Behaviour:
- Reset values: busy, done, iot, skip, int_enable = 0; state = ST_IDLE; mb, io_select, io_data_in, ac_out = 0.
- Reset mid-sequence aborts: iot = 0 and state = ST_IDLE on the next edge; no done pulse.
- FSM states: IDLE, SETUP, P1, P2, P4, FIN.
- IDLE:
  - start=1 latches ir into mb and ac_in into a working AC (wac).
  - Clears the skip accumulator.
  - Sets busy=1.
- Opcode dispatch from IDLE:
  - ir[11:9] != 3'b110: go to FIN with no bus activity (iot stays 0); ac_out = ac_in, skip = 0.
  - ir[8:3] == 0 (internal IOT): go to FIN with iot = 0.
    - ir[0] = 1 sets int_enable.
    - ir[1] = 1 clears int_enable.
    - Both set: clear wins.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - iot = 1, state = ST_SETUP; io_select and mb stable.
  - Next state is the first enabled phase in the order P1 (ir[0]), P2 (ir[1]), P4 (ir[2]); if none are enabled, FIN.
- Px phases:
  - Each lasts PHASE_CYCLES cycles with iot = 1 and state = the ST_IOPx code.
  - io_data_in = wac throughout.
  - In the last cycle: wac <= (io_clear_ac ? 0 : wac) | (io_data_avail ? io_data_out : 0); skip accumulator |= io_skip.
  - Next state is the next enabled phase, else FIN.
  - A later phase sees the AC as updated by the earlier phase.
- FIN (1 cycle):
  - iot = 0, state = ST_IDLE, done = 1, busy = 0 from the following cycle.
  - ac_out <= wac; skip <= accumulator.
- busy timing: high from the cycle after start through FIN inclusive.
- start while busy=1 is ignored; no queueing.
- Inputs io_* are ignored outside the sampling cycle.
- Latency (start sampled at edge 0, n phase bits set):
  - External IOT: SETUP in cycle 1, done in cycle 2 + n*PHASE_CYCLES.
  - Internal IOT or non-IOT opcode: done in cycle 1.
- io_interrupt changes reflect on int_request in the same cycle.

Test Plan:
- Reset, then ir=6046 (sel 04, IOP2|IOP4), ac_in=0101, PHASE_CYCLES=2, device returns nothing -> iot high in cycles 1-5; state sequence SETUP, IOP2, IOP2, IOP4, IOP4; done in cycle 6; ac_out=0101; skip=0.
- ir=6036 (KRB): device asserts io_clear_ac in the IOP2 sample cycle, then io_data_avail with io_data_out=0215 in IOP4; ac_in=7777 -> ac_out=0215.
- ir=6041 (sel 04, IOP1): io_skip=1 in the IOP1 sample cycle only -> skip=1; done in cycle 4.
- ir=6001 -> int_enable=1, iot never asserted, done in cycle 1. Then io_interrupt=1 -> int_request=1. Then ir=6002 -> int_enable=0, int_request=0. ir=6003 -> int_enable=0.
- start with ir=7200 (non-IOT), ac_in=1234 -> done in cycle 1, ac_out=1234, skip=0. A second start during an external IOT sequence produces no effect and only one done.
- reset asserted in cycle 3 of 6046 -> iot=0 and state=ST_IDLE the next cycle; busy=0; no done; int_enable=0.
